// File: rtl/vending_pkg.sv
// Shared vending definitions: product codes, drink recipes, snack slots,
// the dispenser state encoding and small decode helpers.
package vending_pkg;

   localparam logic [3:0] CODE_ESPRESSO  = 4'd1;
   localparam logic [3:0] CODE_AMERICANO = 4'd2;
   localparam logic [3:0] CODE_LATTE     = 4'd3;
   localparam logic [3:0] CODE_TEA       = 4'd4;
   localparam logic [3:0] CODE_MILK      = 4'd5;
   localparam logic [3:0] CODE_CHOCOLATE = 4'd6;
   localparam logic [3:0] CODE_NUTS      = 4'd7;
   localparam logic [3:0] CODE_SNICKERS  = 4'd8;

   localparam logic [1:0] DOSER_COFFEE = 2'd0;
   localparam logic [1:0] DOSER_TEA    = 2'd1;

   localparam logic [2:0] SLOT_NONE      = 3'b000;
   localparam logic [2:0] SLOT_CHOCOLATE = 3'b001;
   localparam logic [2:0] SLOT_NUTS      = 3'b010;
   localparam logic [2:0] SLOT_SNICKERS  = 3'b100;

   // Phase durations are in recipe ticks.
   typedef struct packed {
      logic [15:0] dose;
      logic [15:0] water;
      logic [15:0] milk;
      logic [1:0]  sel;
   } recipe_t;

   localparam recipe_t RCP_ESPRESSO  = {16'd8, 16'd20, 16'd0,  DOSER_COFFEE};
   localparam recipe_t RCP_AMERICANO = {16'd8, 16'd40, 16'd0,  DOSER_COFFEE};
   localparam recipe_t RCP_LATTE     = {16'd8, 16'd20, 16'd30, DOSER_COFFEE};
   localparam recipe_t RCP_TEA       = {16'd6, 16'd40, 16'd0,  DOSER_TEA};
   localparam recipe_t RCP_MILK      = {16'd0, 16'd0,  16'd40, DOSER_COFFEE};
   localparam recipe_t RCP_NONE      = {16'd0, 16'd0,  16'd0,  DOSER_COFFEE};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CUP   = 3'd1,
      DOSE  = 3'd2,
      WATER = 3'd3,
      MILK  = 3'd4,
      MOTOR = 3'd5,
      DONE  = 3'd6,
      REARM = 3'd7
   } state_e;

   function automatic recipe_t recipe_of(input logic [3:0] code);
      case (code)
         CODE_ESPRESSO:  return RCP_ESPRESSO;
         CODE_AMERICANO: return RCP_AMERICANO;
         CODE_LATTE:     return RCP_LATTE;
         CODE_TEA:       return RCP_TEA;
         CODE_MILK:      return RCP_MILK;
         default:        return RCP_NONE;
      endcase
   endfunction

   function automatic logic [2:0] slot_of(input logic [3:0] code);
      case (code)
         CODE_CHOCOLATE: return SLOT_CHOCOLATE;
         CODE_NUTS:      return SLOT_NUTS;
         CODE_SNICKERS:  return SLOT_SNICKERS;
         default:        return SLOT_NONE;
      endcase
   endfunction

   function automatic logic is_drink(input logic [3:0] code);
      return (code >= CODE_ESPRESSO) && (code <= CODE_MILK);
   endfunction

   function automatic logic is_snack(input logic [3:0] code);
      return (code >= CODE_CHOCOLATE) && (code <= CODE_SNICKERS);
   endfunction

   // Next drink phase after 'cur', skipping phases of zero duration.
   function automatic state_e next_phase(input state_e cur, input recipe_t r);
      state_e nxt;
      nxt = DONE;
      case (cur)
         CUP: begin
            if (r.dose != 16'd0)       nxt = DOSE;
            else if (r.water != 16'd0) nxt = WATER;
            else if (r.milk != 16'd0)  nxt = MILK;
            else                       nxt = DONE;
         end
         DOSE: begin
            if (r.water != 16'd0)      nxt = WATER;
            else if (r.milk != 16'd0)  nxt = MILK;
            else                       nxt = DONE;
         end
         WATER: begin
            if (r.milk != 16'd0)       nxt = MILK;
            else                       nxt = DONE;
         end
         default: nxt = DONE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/product_dispenser_if.sv
// Product port between the vending controller (master) and the dispenser (slave).
interface product_dispenser_if;
   logic [3:0] i_product_code;
   logic       i_product_valid;
   logic       o_product_ready;
   logic       o_busy;
   logic       o_fault;

   modport master (
      output i_product_code, i_product_valid,
      input  o_product_ready, o_busy, o_fault
   );

   modport slave (
      input  i_product_code, i_product_valid,
      output o_product_ready, o_busy, o_fault
   );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter with a one-cycle tick in the wrap cycle.
// 'restart' forces the count back to 0 so a phase starts on a clean tick grid.
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Next count: restart, wrap or increment; tick marks the last count.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = 16'd0;
      end else if (cnt_q == LAST) begin
         cnt_d = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
      tick = (cnt_q == LAST);
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/product_dispenser.sv
// Product dispenser: runs a drink recipe or a snack spiral for one accepted
// product code, then pulses ready. All outputs are decoded from the next
// state and registered, so they change on the edge that changes the state.
module product_dispenser
   import vending_pkg::*;
#(
   parameter int TICK_DIV            = 1000,
   parameter int CUP_TICKS           = 4,
   parameter int MOTOR_TIMEOUT_TICKS = 50
) (
   input  logic                i_clk,
   input  logic                i_rst,
   product_dispenser_if.slave  bus,
   input  logic                i_drop_sense,
   output logic                o_cup_drop,
   output logic                o_doser_en,
   output logic [1:0]          o_doser_sel,
   output logic                o_water_en,
   output logic                o_milk_en,
   output logic [2:0]          o_motor_en
);
   localparam logic [15:0] CUP_LAST     = 16'(CUP_TICKS - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(MOTOR_TIMEOUT_TICKS - 1);

   state_e      state_q, state_d;
   logic [3:0]  code_q, code_d;
   logic [15:0] ticks_q, ticks_d;
   logic        fault_q, fault_d;
   logic        restart_s, tick_s;
   recipe_t     rec_s, rec_d_s;

   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        cup_q, cup_d;
   logic        doser_en_q, doser_en_d;
   logic [1:0]  doser_sel_q, doser_sel_d;
   logic        water_q, water_d;
   logic        milk_q, milk_d;
   logic [2:0]  motor_q, motor_d;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk     (i_clk),
      .rst     (i_rst),
      .restart (restart_s),
      .tick    (tick_s)
   );

   // Next-state, code latch, fault and phase tick counter.
   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      fault_d   = fault_q;
      restart_s = 1'b0;
      rec_s     = recipe_of(code_q);
      if (tick_s) begin
         ticks_d = ticks_q + 16'd1;
      end else begin
         ticks_d = ticks_q;
      end
      case (state_q)
         IDLE: begin
            if (bus.i_product_valid) begin
               code_d  = bus.i_product_code;
               fault_d = 1'b0;
               if (is_drink(bus.i_product_code)) begin
                  state_d = CUP;
               end else if (is_snack(bus.i_product_code)) begin
                  state_d = MOTOR;
               end else begin
                  state_d = DONE;
                  fault_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CUP: begin
            if (tick_s && (ticks_q == CUP_LAST)) state_d = next_phase(CUP, rec_s);
            else                                 state_d = CUP;
         end
         DOSE: begin
            if (tick_s && (ticks_q == rec_s.dose - 16'd1)) state_d = next_phase(DOSE, rec_s);
            else                                           state_d = DOSE;
         end
         WATER: begin
            if (tick_s && (ticks_q == rec_s.water - 16'd1)) state_d = next_phase(WATER, rec_s);
            else                                            state_d = WATER;
         end
         MILK: begin
            if (tick_s && (ticks_q == rec_s.milk - 16'd1)) state_d = DONE;
            else                                           state_d = MILK;
         end
         MOTOR: begin
            // A drop in the timeout cycle still counts as a good vend.
            if (i_drop_sense) begin
               state_d = DONE;
            end else if (tick_s && (ticks_q == TIMEOUT_LAST)) begin
               state_d = DONE;
               fault_d = 1'b1;
            end else begin
               state_d = MOTOR;
            end
         end
         DONE:  state_d = REARM;
         REARM: begin
            if (!bus.i_product_valid) state_d = IDLE;
            else                      state_d = REARM;
         end
         default: state_d = IDLE;
      endcase
      // Every phase entry starts on a fresh tick grid with a zero tick count.
      if (state_d != state_q) begin
         ticks_d   = 16'd0;
         restart_s = 1'b1;
      end else begin
         restart_s = 1'b0;
      end
   end

   // Output decode from the next state so actuators track the state edge.
   always_comb begin
      rec_d_s    = recipe_of(code_d);
      ready_d    = (state_d == DONE);
      busy_d     = (state_d != IDLE);
      cup_d      = (state_d == CUP);
      doser_en_d = (state_d == DOSE);
      water_d    = (state_d == WATER);
      milk_d     = (state_d == MILK);
      if (state_d == DOSE) doser_sel_d = rec_d_s.sel;
      else                 doser_sel_d = 2'd0;
      if (state_d == MOTOR) motor_d = slot_of(code_d);
      else                  motor_d = SLOT_NONE;
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         code_q      <= 4'd0;
         ticks_q     <= 16'd0;
         fault_q     <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         cup_q       <= 1'b0;
         doser_en_q  <= 1'b0;
         doser_sel_q <= 2'd0;
         water_q     <= 1'b0;
         milk_q      <= 1'b0;
         motor_q     <= 3'b000;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         ticks_q     <= ticks_d;
         fault_q     <= fault_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         cup_q       <= cup_d;
         doser_en_q  <= doser_en_d;
         doser_sel_q <= doser_sel_d;
         water_q     <= water_d;
         milk_q      <= milk_d;
         motor_q     <= motor_d;
      end
   end

   assign bus.o_product_ready = ready_q;
   assign bus.o_busy          = busy_q;
   assign bus.o_fault         = fault_q;
   assign o_cup_drop          = cup_q;
   assign o_doser_en          = doser_en_q;
   assign o_doser_sel         = doser_sel_q;
   assign o_water_en          = water_q;
   assign o_milk_en           = milk_q;
   assign o_motor_en          = motor_q;
endmodule
